spmm_job_sched: RTL
===================

SPMM_JOB_SCHED -- requirements
Module: spmm_job_sched

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing one SpMM core.
REQ-002 Parameter CLR_CYCLES, default 2, cycles core_rst_o is held high before start.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, maximum RUN-state cycles before abort.
REQ-004 clk_i  input  1  clock; all logic on its rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 req_valid_i  input  NUM_REQ  per-requester job request.
REQ-007 req_ready_o  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-008 req_rows_i  input  NUM_REQ x 4  row count of matrix A per requester.
REQ-009 req_tag_i  input  NUM_REQ x 4  opaque job tag per requester.
REQ-010 core_sel_o  output  $clog2(NUM_REQ)  selects which requester's CSR arrays feed the core.
REQ-011 core_rst_o  output  1  reset to the core; loads its buffers and row count.
REQ-012 core_start_o  output  1  one-cycle start pulse to the core.
REQ-013 core_rows_o  output  4  registered row count driven to the core.
REQ-014 core_busy_i  input  1  core computing status.
REQ-015 core_done_i  input  1  core operation-complete status, level.
REQ-016 rsp_valid_o / rsp_ready_i  output / input  1 / 1  response handshake.
REQ-017 rsp_id_o  output  $clog2(NUM_REQ)  granted requester index.
REQ-018 rsp_tag_o  output  4  tag of the completed job.
REQ-019 rsp_timeout_o  output  1  job aborted by timeout.

Function
REQ-020 FSM states IDLE, CLR, START, RUN, RESP; reset state IDLE.
REQ-021 IDLE: if any req_valid_i is high, grant round-robin starting one above the last granted index; pulse req_ready_o for that requester for one cycle; latch id, tag, and rows; go to CLR.
REQ-022 A request is accepted only in the cycle where req_valid_i and req_ready_o are both high.
REQ-023 CLR: core_rst_o=1 for exactly CLR_CYCLES cycles with core_sel_o and core_rows_o stable; then go to START.
REQ-024 START: core_start_o=1 for exactly one cycle; go to RUN.
REQ-025 RUN: on core_done_i=1, go to RESP with timeout flag 0.
REQ-026 RESP: rsp_valid_o=1 with id, tag, and timeout stable until rsp_ready_i=1; then go to IDLE; the core is not re-reset.
REQ-027 Grant latency: IDLE with a valid request to core_start_o is exactly CLR_CYCLES+2 cycles.
REQ-028 core_sel_o and core_rows_o hold the granted job's values from CLR through RESP.
REQ-029 Requests arriving outside IDLE are ignored until IDLE; req_valid_i dropped before grant is not a request.
REQ-030 core_done_i already high on RUN entry is treated as stale for the first RUN cycle, then honoured.
REQ-031 Round-robin pointer updates only on grant; with a single active requester it is granted back-to-back.

Reset
REQ-032 rst_i high forces outputs low: req_ready_o=0, core_start_o=0, rsp_valid_o=0, rsp_id_o=0, rsp_tag_o=0, rsp_timeout_o=0, core_sel_o=0, core_rows_o=0, rr pointer=NUM_REQ-1.
REQ-033 core_rst_o=1 while rst_i is high, and for the cycle following deassertion.
REQ-034 Reset mid-job discards the job with no response.

Configuration
REQ-035 Macro SPMM_SCHED_TIMEOUT_EN defined: a RUN cycle counter is kept; when it reaches TIMEOUT_CYCLES without core_done_i, core_rst_o is asserted for 1 cycle and the FSM goes to RESP with rsp_timeout_o=1.
REQ-036 SPMM_SCHED_TIMEOUT_EN undefined: no counter; RUN waits indefinitely; rsp_timeout_o is tied 0.

Structure
REQ-037 Shared package spmm_pkg holds the FSM state enum, the job-descriptor struct (id, tag, rows), and default parameter constants.
REQ-038 Sub-module rr_arbiter (NUM_REQ-wide, request vector plus pointer in, one-hot grant out) is instantiated once.

Verification
REQ-039 Single request: req0 rows=3 tag=5 -> ready0 pulse; core_rst_o high 2 cycles; core_start_o at cycle 4; done after 10 cycles -> rsp id=0, tag=5, timeout=0.
REQ-040 Contention: req0 and req1 both valid continuously -> grants alternate 0,1,0,1 across 4 jobs.
REQ-041 Backpressure: rsp_ready_i low 5 cycles -> rsp fields stable, no new grant until the handshake completes.
REQ-042 Timeout (macro on, TIMEOUT_CYCLES=16): core_done_i never rises -> after 16 RUN cycles core_rst_o pulses and rsp_timeout_o=1.
REQ-043 Reset mid-RUN: rst_i asserted during RUN -> IDLE, all outputs at reset values, no response, next request granted normally.
REQ-044 Stale done: core_done_i high entering RUN -> ignored for 1 cycle; response only if still high on the next cycle.

Source files
------------

// File: rtl/spmm_pkg.sv
// Shared types and defaults for the SpMM job scheduler: FSM state encoding,
// the latched job descriptor, and default parameter values.
package spmm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLR,
      ST_START,
      ST_RUN,
      ST_RESP
   } state_e;

   localparam int ID_W   = 4;
   localparam int TAG_W  = 4;
   localparam int ROWS_W = 4;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [TAG_W-1:0]  tag;
      logic [ROWS_W-1:0] rows;
   } job_t;

   localparam int DEF_NUM_REQ        = 2;
   localparam int DEF_CLR_CYCLES     = 2;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches the request vector starting one above the
// last granted index and returns a one-hot grant (zero when nothing requests).
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o
);

   logic             found;
   logic [IDX_W-1:0] idx;

   // First requester found after the pointer, wrapping around, wins.
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spmm_job_sched.sv
// SpMM job scheduler: arbitrates requesters onto one SpMM core, clears and
// starts the core, waits for completion and returns a tagged response.
// Optional macro SPMM_SCHED_TIMEOUT_EN adds a RUN-state watchdog that aborts
// the job after TIMEOUT_CYCLES and reports it through rsp_timeout_o.
module spmm_job_sched
   import spmm_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int CLR_CYCLES     = DEF_CLR_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   output logic [NUM_REQ-1:0]         req_ready_o,
   input  logic [NUM_REQ*4-1:0]       req_rows_i,
   input  logic [NUM_REQ*4-1:0]       req_tag_i,
   output logic [$clog2(NUM_REQ)-1:0] core_sel_o,
   output logic                       core_rst_o,
   output logic                       core_start_o,
   output logic [3:0]                 core_rows_o,
   input  logic                       core_busy_i,
   input  logic                       core_done_i,
   output logic                       rsp_valid_o,
   input  logic                       rsp_ready_i,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
   output logic [3:0]                 rsp_tag_o,
   output logic                       rsp_timeout_o
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CLR_W = $clog2(CLR_CYCLES + 1);

   state_e              state_q, state_d;
   job_t                job_q;
   logic [IDX_W-1:0]    rr_ptr_q;
   logic [CLR_W-1:0]    clr_cnt_q;
   logic                core_rst_p1, core_start_p1;
   logic [NUM_REQ-1:0]  gnt;
   logic [IDX_W-1:0]    gnt_idx;
   logic [TAG_W-1:0]    gnt_tag;
   logic [ROWS_W-1:0]   gnt_rows;
   logic                accept, done_ok, to_hit;
   logic                busy_unused;

   // Completion is judged by core_done_i alone; busy is status only.
   assign busy_unused = core_busy_i;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req_i (req_valid_i),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt)
   );

   // Decode the one-hot grant into an index and select that requester's fields.
   always_comb begin
      gnt_idx  = '0;
      gnt_tag  = '0;
      gnt_rows = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            gnt_idx  = IDX_W'(i);
            gnt_tag  = req_tag_i[i*TAG_W +: TAG_W];
            gnt_rows = req_rows_i[i*ROWS_W +: ROWS_W];
         end
      end
   end

   // The arbiter only grants valid requesters, so any valid in IDLE is accepted.
   assign accept  = (state_q == ST_IDLE) && (|req_valid_i);
   // core_start_p1 is high exactly in the first RUN cycle, where done is stale.
   assign done_ok = core_done_i && !core_start_p1;

`ifdef SPMM_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] to_cnt_q;
   logic            timeout_q;

   assign to_hit = (state_q == ST_RUN) && !done_ok &&
                   (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   // Count RUN cycles and remember whether the job ended by timeout.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         to_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state_q == ST_RUN) to_cnt_q <= to_cnt_q + 1'b1;
         else                   to_cnt_q <= '0;
         if (accept)      timeout_q <= 1'b0;
         else if (to_hit) timeout_q <= 1'b1;
      end
   end

   assign rsp_timeout_o = timeout_q;
`else
   localparam int timeout_unused = TIMEOUT_CYCLES;

   assign to_hit        = 1'b0;
   assign rsp_timeout_o = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic for the job sequence.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = ST_CLR;
         ST_CLR:   if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) state_d = ST_START;
         ST_START: state_d = ST_RUN;
         ST_RUN:   if (done_ok || to_hit) state_d = ST_RESP;
         ST_RESP:  if (rsp_ready_i) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Count CLR cycles; cleared whenever the FSM is elsewhere.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                  clr_cnt_q <= '0;
      else if (state_q == ST_CLR) clr_cnt_q <= clr_cnt_q + 1'b1;
      else                        clr_cnt_q <= '0;
   end

   // Registered core strobes; core_rst_p1 leaves reset high so the core is held one extra cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         core_rst_p1   <= 1'b1;
         core_start_p1 <= 1'b0;
      end else begin
         core_rst_p1   <= (state_q == ST_CLR) || to_hit;
         core_start_p1 <= (state_q == ST_START);
      end
   end

   // Latch the granted job and advance the round-robin pointer on grant only.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         job_q    <= '0;
         rr_ptr_q <= IDX_W'(NUM_REQ - 1);
      end else if (accept) begin
         job_q.id   <= ID_W'(gnt_idx);
         job_q.tag  <= gnt_tag;
         job_q.rows <= gnt_rows;
         rr_ptr_q   <= gnt_idx;
      end
   end

   assign req_ready_o  = (state_q == ST_IDLE) ? gnt : '0;
   assign core_sel_o   = IDX_W'(job_q.id);
   assign core_rows_o  = job_q.rows;
   assign core_rst_o   = core_rst_p1;
   assign core_start_o = core_start_p1;
   assign rsp_valid_o  = (state_q == ST_RESP);
   assign rsp_id_o     = IDX_W'(job_q.id);
   assign rsp_tag_o    = job_q.tag;

endmodule
